// File: rtl/bp_update_sched_pkg.sv
// Shared types for the branch-predictor update scheduler: PHT op codes,
// scheduler FSM states and the queued update record.
package tcore_param;

  localparam int BP_PHT_SIZE = 128;
  // GHR field is sized for the largest supported table; users take the low IDX_W bits.
  localparam int BP_GHR_W    = 16;

  typedef enum logic [1:0] {
    PHT_OP_NOP  = 2'b00,
    PHT_OP_INIT = 2'b01,
    PHT_OP_INC  = 2'b10,
    PHT_OP_DEC  = 2'b11
  } bp_pht_op_e;

  typedef enum logic [1:0] {
    SCHED_INIT  = 2'b00,
    SCHED_RUN   = 2'b01,
    SCHED_FLUSH = 2'b10
  } bp_sched_state_e;

  typedef struct packed {
    logic [31:0]         pc;
    logic [BP_GHR_W-1:0] ghr;
    logic                taken;
    logic [31:0]         target;
  } bp_upd_t;

  function automatic bp_pht_op_e bp_dir_op(input logic taken);
    return taken ? PHT_OP_INC : PHT_OP_DEC;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO of resolved branch updates with a single-cycle clear.
// Push when full and pop when empty are ignored; clear wins over both.
module bp_upd_fifo
  import tcore_param::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_clr,
  input  logic    i_push,
  input  logic    i_pop,
  input  bp_upd_t i_data,
  output bp_upd_t o_head,
  output logic    o_empty,
  output logic    o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  bp_upd_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_push  = i_push && !o_full && !i_clr;
  assign w_pop   = i_pop && !o_empty && !i_clr;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// Branch-predictor table write scheduler: walks the PHT/BTB to a known state after
// reset or flush, then drains queued branch-resolution updates one write per cycle.
module bp_update_sched
  import tcore_param::*;
#(
  parameter int PHT_SIZE   = BP_PHT_SIZE,
  parameter int BTB_SIZE   = BP_PHT_SIZE,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = $clog2(PHT_SIZE),
  localparam int TAG_W     = 32 - IDX_W - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_req_i,
  // Update handshake: an update transfers on a rising edge where upd_valid_i and
  // upd_ready_o are both high; the payload must be stable while upd_valid_i is high.
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [31:0]      upd_pc_i,
  input  logic [IDX_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_pht_idx_o,
  output logic [1:0]       tbl_pht_op_o,
  output logic [IDX_W-1:0] tbl_btb_idx_o,
  output logic [TAG_W-1:0] tbl_btb_tag_o,
  output logic [31:0]      tbl_btb_target_o,
  output logic             bp_ready_o,
  output logic [1:0]       dbg_state_o
);

  if (BTB_SIZE != PHT_SIZE) begin : g_bad_btb_size
    $error("bp_update_sched: BTB_SIZE must equal PHT_SIZE");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHT_SIZE - 1);

  bp_sched_state_e  r_state;
  logic [IDX_W-1:0] r_walk_idx;
  logic             r_ready;

  bp_upd_t w_push_data;
  bp_upd_t w_head;
  logic    w_fifo_empty;
  logic    w_fifo_full;
  logic    w_walking;
  logic    w_run;
  logic    w_flush_run;
  logic    w_push;
  logic    w_pop;
  logic    w_unused;

  // Gate with rst_ni so no write strobe escapes while reset is held.
  assign w_walking   = rst_ni && ((r_state == SCHED_INIT) || (r_state == SCHED_FLUSH));
  assign w_run       = (r_state == SCHED_RUN);
  assign w_flush_run = w_run && flush_req_i;

  assign upd_ready_o = w_run && !w_fifo_full && !flush_req_i;
  assign w_push      = upd_valid_i && upd_ready_o;
  assign w_pop       = w_run && !w_fifo_empty && !stall_i && !flush_req_i;

  assign w_push_data = '{pc:     upd_pc_i,
                         ghr:    BP_GHR_W'(upd_ghr_i),
                         taken:  upd_taken_i,
                         target: upd_target_i};

  bp_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_flush_run),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= SCHED_INIT;
      r_walk_idx <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        SCHED_INIT, SCHED_FLUSH: begin
          // Flush requests are deliberately ignored here: the walk already clears everything.
          if (!stall_i) begin
            if (r_walk_idx == LAST_IDX) begin
              r_state    <= SCHED_RUN;
              r_ready    <= 1'b1;
              r_walk_idx <= '0;
            end else begin
              r_walk_idx <= r_walk_idx + 1'b1;
            end
          end
        end
        SCHED_RUN: begin
          if (flush_req_i) begin
            r_state    <= SCHED_FLUSH;
            r_ready    <= 1'b0;
            r_walk_idx <= '0;
          end
        end
        default: begin
          r_state    <= SCHED_INIT;
          r_ready    <= 1'b0;
          r_walk_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    tbl_we_o         = 1'b0;
    tbl_pht_idx_o    = '0;
    tbl_pht_op_o     = PHT_OP_NOP;
    tbl_btb_idx_o    = '0;
    tbl_btb_tag_o    = '0;
    tbl_btb_target_o = '0;
    if (w_walking && !stall_i) begin
      tbl_we_o      = 1'b1;
      tbl_pht_idx_o = r_walk_idx;
      tbl_pht_op_o  = PHT_OP_INIT;
      tbl_btb_idx_o = r_walk_idx;
    end else if (w_pop) begin
      tbl_we_o      = 1'b1;
      tbl_pht_idx_o = w_head.pc[IDX_W:1] ^ w_head.ghr[IDX_W-1:0];
      tbl_pht_op_o  = bp_dir_op(w_head.taken);
      tbl_btb_idx_o = w_head.pc[IDX_W:1];
      // Not-taken branches invalidate the BTB entry rather than allocate it.
      if (w_head.taken) begin
        tbl_btb_tag_o    = w_head.pc[31:IDX_W+1];
        tbl_btb_target_o = w_head.target;
      end
    end
  end

  assign bp_ready_o  = r_ready;
  assign dbg_state_o = r_state;

  assign w_unused = ^{w_head.pc[0], w_head.ghr};

endmodule

// File: doc/bp_update_sched.md
BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 SHALL have parameter PHT_SIZE, default 128, PHT entries (power of two); IDX_W = log2(PHT_SIZE).
REQ-002 SHALL have parameter BTB_SIZE, default 128, BTB entries; SHALL equal PHT_SIZE.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pending-update entries (power of two).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 stall_i  in  1  pipeline stall; freezes table writes and walk.
REQ-008 flush_req_i  in  1  predictor flush request (fence.i / context switch), one-cycle pulse.
REQ-009 upd_valid_i  in  1  resolved conditional branch update offered.
REQ-010 upd_ready_o  out  1  update accepted when upd_valid_i && upd_ready_o.
REQ-011 upd_pc_i  in  32  branch PC.
REQ-012 upd_ghr_i  in  IDX_W  GHR slice captured at prediction.
REQ-013 upd_taken_i  in  1  resolved outcome.
REQ-014 upd_target_i  in  32  resolved target.
REQ-015 tbl_we_o  out  1  table write strobe this cycle.
REQ-016 tbl_pht_idx_o  out  IDX_W  PHT write index.
REQ-017 tbl_pht_op_o  out  2  PHT op: INIT(set 2'b01), INC(sat), DEC(sat), NOP.
REQ-018 tbl_btb_idx_o  out  IDX_W  BTB write index.
REQ-019 tbl_btb_tag_o  out  32-IDX_W-1  BTB tag, PC[31:IDX_W+1].
REQ-020 tbl_btb_target_o  out  32  BTB target.
REQ-021 bp_ready_o  out  1  tables valid; fetch SHALL treat predictions as not-taken while low.

Function
REQ-022 FSM states INIT, RUN, FLUSH; INIT/FLUSH walk an index counter 0..PHT_SIZE-1, one entry per non-stalled cycle, tbl_we_o=1, op=INIT, btb tag/target=0, both idx=counter.
REQ-023 Walk completion: after index PHT_SIZE-1 written, next state RUN, bp_ready_o=1 from that edge; walk takes exactly PHT_SIZE non-stalled cycles.
REQ-024 stall_i=1 SHALL hold walk counter, FIFO contents and force tbl_we_o=0.
REQ-025 upd_ready_o = (state==RUN) && !fifo_full && !flush_req_i; no push-pop bypass when full.
REQ-026 In RUN with FIFO non-empty and !stall_i: pop head, tbl_we_o=1, pht_idx=pc[IDX_W:1]^ghr, btb_idx=pc[IDX_W:1], op=taken?INC:DEC, tag/target = taken ? pc[31:IDX_W+1]/target : 0; one write per cycle.
REQ-027 Update latency: accepted update written no earlier than the cycle after acceptance; FIFO order preserved.
REQ-028 Simultaneous push and pop when not full: both occur, count unchanged.
REQ-029 flush_req_i in RUN: FIFO cleared, no write that cycle, state FLUSH, counter=0, bp_ready_o=0 next cycle.
REQ-030 flush_req_i in INIT or FLUSH: ignored (walk continues).
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter IDX log2(FIFO_DEPTH)+1 bits.
REQ-032 Idle outputs (tbl_we_o=0): idx/tag/target=0, op=NOP.

Reset
REQ-033 On rst_ni low: state INIT, counter 0, FIFO empty, bp_ready_o=0, upd_ready_o=0, tbl_we_o=0; reset mid-walk restarts walk at index 0.

Structure
REQ-034 tcore_param SHALL hold bp_pht_op_e (INIT/INC/DEC/NOP), bp_sched_state_e, bp_upd_t struct {pc, ghr, taken, target}, BP_PHT_SIZE constant.
REQ-035 One sub-module: bp_upd_fifo (synchronous FIFO of bp_upd_t, clear input).

Verification
REQ-036 Release reset, no stall -> tbl_we_o high 128 cycles, idx 0..127, op INIT; bp_ready_o rises cycle 129.
REQ-037 Stall 10 cycles at index 50 -> index 50 held, no writes, bp_ready_o rises 10 cycles later.
REQ-038 RUN, update pc=0x0000_0104, ghr=0x05, taken, target=0x200 -> pht_idx=0x07, btb_idx=0x02, op INC, tag=0x000001, target=0x200.
REQ-039 Push 5 updates back-to-back with stall_i=1 -> 4 accepted, upd_ready_o low on 5th; release stall -> 4 writes in order.
REQ-040 flush_req_i with 3 queued + upd_valid_i same cycle -> update rejected, FIFO empty, 128-cycle walk, bp_ready_o low throughout.
REQ-041 Assert rst_ni low at walk index 90 -> after release walk restarts at 0.
